seq_magnitude_comparator: RTL and testbench
===========================================

# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator: the successor to the combinational 4-bit equality comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, starting from the most significant slice, and stops as soon as a slice differs. It reports equal, less and greater, supports signed or unsigned comparison per operation, and uses a start/busy/done handshake. It serves datapath blocks that need wide compares without a wide single-cycle comparator.

## Interface
Parameters:
- WIDTH, 32: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- SIGNED_EN, 1: 1 enables two's-complement mode; 0 forces unsigned and ignores signed_mode.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when results update.
- equal  out  1  A == B for the last completed compare.
- less  out  1  A < B for the last completed compare.
- greater  out  1  A > B for the last completed compare.

## Operation
- NDIG = WIDTH/DIGIT slices. The slice counter is sized $clog2(NDIG+1).
- Two-state FSM: IDLE and SCAN.
- IDLE -> SCAN on start:
  - Latch a and b into shift registers sa and sb.
  - Signed mode (SIGNED_EN=1 and signed_mode=1): invert bit WIDTH-1 of both latched copies. This is an offset-binary transform; all later compares are unsigned.
  - Clear the slice counter.
- SCAN, each cycle:
  - Compare the top DIGIT bits of sa and sb.
  - If they differ: register less/greater from the unsigned slice compare, set equal=0, pulse done, go to IDLE.
  - Else if this is slice NDIG-1: register equal=1 and less=greater=0, pulse done, go to IDLE.
  - Else: shift sa and sb left by DIGIT, increment the counter, stay in SCAN.
- Outputs:
  - busy = (state == SCAN).
  - equal, less and greater are registered. They change only in the cycle done goes high and hold until the next done.
  - After the first completion, exactly one of the three is high.
- Boundary and corner cases:
  - start while busy: ignored; operand changes while busy have no effect.
  - start high in the cycle done is high: accepted, because the FSM is already in IDLE. This gives back-to-back operation with no bubble.
  - rst in any state: forces IDLE on the next edge and clears busy, done, equal, less and greater to 0. Any in-flight compare is discarded and no done is produced for it.
  - WIDTH == DIGIT: every compare completes in 1 cycle.

## Timing
- Reset values: busy=0, done=0, equal=0, less=0, greater=0, state=IDLE.
- Start edge: start is sampled at edge E0. busy is high after E0.
- First differing slice k (k = 1 for the MSB slice): results and done are registered at edge Ek.
  - Latency from start edge to done high is k cycles.
  - Best case is 1 cycle; the worst case (including equal) is NDIG cycles.
- busy and done are never high together. busy falls at the same edge where done rises.
- done is high for exactly one cycle per accepted start.

## Test plan
Parameters for all scenarios: WIDTH=32, DIGIT=4, SIGNED_EN=1.
- **Equal:** a=b=0xDEADBEEF, unsigned. Required: done 8 cycles after start; equal=1, less=0, greater=0; busy high for exactly 8 cycles.
- **Early exit:** a=0x80000000, b=0x7FFFFFFF.
  - Unsigned: done after 1 cycle, greater=1.
  - Repeat with signed_mode=1: done after 1 cycle, less=1.
- **Signed sign-bit case, then LSB difference:**
  - a=0xFFFFFFFF (−1), b=0x00000001, signed: less=1 after 1 cycle.
  - a=0x12345678, b=0x12345679, unsigned: less=1 after 8 cycles.
- **Mid slice:** a=0x12400000, b=0x12300000. Required: greater=1, done exactly 3 cycles after start.
- **Handshake:**
  - Pulse start with different operands during busy: no effect on the result, and done pulses only once.
  - Assert start in the done cycle with a=5, b=9: accepted immediately; the second done follows with less=1.
- **Reset mid-scan:** assert rst at cycle 4 of an equal compare. Required:
  - Next cycle: busy=0, done=0, and equal/less/greater all 0.
  - No done pulse is produced for the discarded compare.
  - A following compare of a=3, b=3 gives equal=1 after 8 cycles.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands DIGIT bits per
// cycle from the MSB slice down and stops at the first slice that differs.
module seq_magnitude_comparator #(
    parameter int WIDTH     = 32,
    parameter int DIGIT     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             less,
    output logic             greater,
    output logic             dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_SLICE = CW'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             equal_q, equal_d;
    logic             less_q, less_d;
    logic             greater_q, greater_d;

    logic [DIGIT-1:0] top_a;
    logic [DIGIT-1:0] top_b;
    logic             sign_flip;

    assign top_a     = sa_q[WIDTH-1 -: DIGIT];
    assign top_b     = sb_q[WIDTH-1 -: DIGIT];
    assign sign_flip = (SIGNED_EN != 0) && signed_mode;

    // Handshake: start is taken only in IDLE (including the done cycle, which is
    // already IDLE); busy is high while scanning; done pulses for one cycle in
    // the same cycle busy drops and the result registers update.
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        equal_d   = equal_q;
        less_d    = less_q;
        greater_d = greater_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping both sign bits maps two's complement onto offset
                    // binary, so the scan itself is always unsigned.
                    sa_d            = a;
                    sb_d            = b;
                    sa_d[WIDTH-1]   = a[WIDTH-1] ^ sign_flip;
                    sb_d[WIDTH-1]   = b[WIDTH-1] ^ sign_flip;
                    cnt_d           = '0;
                    state_d         = SCAN;
                end
            end
            SCAN: begin
                if (top_a != top_b) begin
                    less_d    = (top_a < top_b);
                    greater_d = (top_a > top_b);
                    equal_d   = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == LAST_SLICE) begin
                    equal_d   = 1'b1;
                    less_d    = 1'b0;
                    greater_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            equal_q   <= 1'b0;
            less_q    <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            equal_q   <= equal_d;
            less_q    <= less_d;
            greater_q <= greater_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = done_q;
    assign equal     = equal_q;
    assign less      = less_q;
    assign greater   = greater_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and randomized bench for seq_magnitude_comparator (WIDTH=32, DIGIT=4,
// SIGNED_EN=1) with a behavioural reference model and an expected-result queue.
module tb_seq_magnitude_comparator;

    localparam int W = 32;
    localparam int MAX_WAIT = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         equal;
    logic         less;
    logic         greater;
    logic         dbg_state;

    int checks;
    int errors;

    // Expected word: {latency[7:0], equal, less, greater}
    logic [10:0] exp_q[$];

    seq_magnitude_comparator #(
        .WIDTH(32),
        .DIGIT(4),
        .SIGNED_EN(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_mode(signed_mode),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .equal(equal),
        .less(less),
        .greater(greater),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the scan stops at the first 4-bit slice (from the MSB)
    // where the operands differ; flipping both sign bits leaves that unchanged.
    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x ^ y;
        for (int i = 0; i < 8; i++) begin
            if (d[31-4*i -: 4] != 4'h0) return i + 1;
        end
        return 8;
    endfunction

    function automatic logic [10:0] ref_result(input logic [31:0] x, input logic [31:0] y,
                                               input logic sm);
        logic lt, gt, eq;
        int   lat;
        if (sm) begin
            lt = ($signed(x) < $signed(y));
            gt = ($signed(x) > $signed(y));
        end else begin
            lt = (x < y);
            gt = (x > y);
        end
        eq  = (x == y);
        lat = ref_latency(x, y);
        return {lat[7:0], eq, lt, gt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver + monitor for one isolated compare.
    task automatic compare_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                              input logic sm);
        logic [10:0] e;
        int          cyc;
        int          busy_cnt;
        bit          got;
        exp_q.push_back(ref_result(ta, tb_v, sm));
        start       = 1'b1;
        a           = ta;
        b           = tb_v;
        signed_mode = sm;
        step();
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        busy_cnt = 1;
        cyc      = 0;
        got      = 1'b0;
        while (!got && cyc < MAX_WAIT) begin
            step();
            cyc++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        e = exp_q.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, cyc, {24'd0, e[10:3]});
        check({tag, "_equal"}, {31'd0, equal}, {31'd0, e[2]});
        check({tag, "_less"}, {31'd0, less}, {31'd0, e[1]});
        check({tag, "_greater"}, {31'd0, greater}, {31'd0, e[0]});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_busy_cycles"}, busy_cnt, {24'd0, e[10:3]});
        step();
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          cyc;
        int          dones;
        int          done_cyc;
        bit          got;
        logic        res_eq;
        logic [31:0] ra;
        logic [31:0] rb;
        int          pos;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_equal", {31'd0, equal}, 32'd0);
        check("reset_less", {31'd0, less}, 32'd0);
        check("reset_greater", {31'd0, greater}, 32'd0);
        rst = 1'b0;
        step();

        // Directed scenarios
        compare_op("equal", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        compare_op("early_uns", 32'h80000000, 32'h7FFFFFFF, 1'b0);
        compare_op("early_sgn", 32'h80000000, 32'h7FFFFFFF, 1'b1);
        compare_op("neg1_vs_1", 32'hFFFFFFFF, 32'h00000001, 1'b1);
        compare_op("lsb_diff", 32'h12345678, 32'h12345679, 1'b0);
        compare_op("mid_slice", 32'h12400000, 32'h12300000, 1'b0);

        // start pulsed while busy must not disturb the running compare
        start = 1'b1; a = 32'h11111111; b = 32'h11111111; signed_mode = 1'b0;
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1; a = 32'h00000000; b = 32'hFFFFFFFF;
        step();
        start    = 1'b0;
        dones    = 0;
        done_cyc = 0;
        res_eq   = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done) begin
                dones++;
                done_cyc = i;
                res_eq   = equal;
            end
        end
        check("busy_start_dones", dones, 32'd1);
        check("busy_start_timing", done_cyc, 32'd5);
        check("busy_start_equal", {31'd0, res_eq}, 32'd1);

        // start raised in the done cycle is accepted with no bubble
        start = 1'b1; a = 32'h12400000; b = 32'h12300000; signed_mode = 1'b0;
        step();
        start = 1'b0;
        got   = 1'b0;
        cyc   = 0;
        while (!got && cyc < MAX_WAIT) begin
            step();
            cyc++;
            if (done) got = 1'b1;
        end
        check("b2b_first_done", {31'd0, got}, 32'd1);
        check("b2b_first_greater", {31'd0, greater}, 32'd1);
        start = 1'b1; a = 32'd5; b = 32'd9;
        step();
        start = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < MAX_WAIT) begin
            step();
            cyc++;
            if (done) got = 1'b1;
        end
        check("b2b_second_latency", cyc, 32'd8);
        check("b2b_second_less", {31'd0, less}, 32'd1);

        // reset at cycle 4 of an equal compare
        start = 1'b1; a = 32'hCAFEF00D; b = 32'hCAFEF00D;
        step();
        start = 1'b0;
        repeat (3) step();
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_equal", {31'd0, equal}, 32'd0);
        check("rst_less", {31'd0, less}, 32'd0);
        check("rst_greater", {31'd0, greater}, 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) dones++;
        end
        check("rst_no_done", dones, 32'd0);
        compare_op("post_rst", 32'd3, 32'd3, 1'b0);

        // Randomized compares; b differs from a first at a random bit position
        for (int n = 0; n < 40; n++) begin
            ra  = $urandom;
            pos = $urandom_range(0, 32);
            if (pos == 32) rb = ra;
            else rb = ra ^ ((32'h1 << pos) | ($urandom & ((32'h1 << pos) - 32'h1)));
            compare_op("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
